rf_wb_arbiter: RTL and testbench

- Shares the single register-file write port between NUM_REQ write-back requesters, e.g. ALU, load unit and CSR/debug.
- Arbitration is round-robin; the winning write is presented to the register file on registered outputs.
- Holds a per-register pending-write scoreboard so issue logic can stall on read-after-write hazards.
- Sits between the execute/memory stages and the register file.

---
 rtl/rf_wb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
//   Shares the single register-file write port between NUM_REQ write-back
//   requesters. Arbitration is round-robin, or lowest-index-first when the
//   WB_FIXED_PRIO_EN macro is defined. The winning write reaches the register
//   file one cycle later on registered outputs. A per-register pending-write
//   counter lets issue logic stall on read-after-write hazards.
//
// Ports
//   clk, reset             rising-edge clock, async active-high reset
//   req_valid/req_ready    per-requester handshake (ready = granted this cycle)
//   req_addr/req_data      packed per-requester destination and data
//   rf_we/rf_waddr/rf_wdata registered register-file write port
//   issue_valid/issue_addr issuing instruction's destination register
//   issue_ready            pending counter of issue_addr has room
//   chk_addr1/2, chk_busy1/2 hazard queries (register has a pending write)
//
// Build option
//   WB_FIXED_PRIO_EN       fixed priority, requester 0 highest, no pointer
module rf_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  input  logic                      issue_valid,
  input  logic [ADDR_W-1:0]         issue_addr,
  output logic                      issue_ready,
  input  logic [ADDR_W-1:0]         chk_addr1,
  input  logic [ADDR_W-1:0]         chk_addr2,
  output logic                      chk_busy1,
  output logic                      chk_busy2
);

  localparam int NUM_REG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REQ-1:0] w_grant;
  logic               w_xfer;
  logic [ADDR_W-1:0]  w_gnt_addr;
  logic [DATA_W-1:0]  w_gnt_data;

`ifdef WB_FIXED_PRIO_EN
  // Lowest set bit of req_valid wins.
  assign w_grant = req_valid & (~req_valid + NUM_REQ'(1));
`else
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]     r_ptr;
  logic [PTR_W-1:0]     w_gnt_idx;
  logic [2*NUM_REQ-1:0] w_dbl_req;
  logic [2*NUM_REQ-1:0] w_dbl_gnt;
  logic [NUM_REQ-1:0]   w_rot_req;
  logic [NUM_REQ-1:0]   w_rot_gnt;

  // Rotate requests so r_ptr sits at bit 0, take the lowest set bit, then
  // rotate the one-hot grant back into requester numbering.
  always_comb begin
    w_dbl_req = {req_valid, req_valid} >> r_ptr;
    w_rot_req = w_dbl_req[NUM_REQ-1:0];
    w_rot_gnt = w_rot_req & (~w_rot_req + NUM_REQ'(1));
    w_dbl_gnt = {w_rot_gnt, w_rot_gnt} << r_ptr;
    w_grant   = w_dbl_gnt[2*NUM_REQ-1:NUM_REQ];
  end

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_gnt_idx = PTR_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= (w_gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
    end
  end
`endif

  always_comb begin
    w_gnt_addr = '0;
    w_gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
        w_gnt_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign req_ready = w_grant;
  assign w_xfer    = |(req_valid & w_grant);

  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;

  // Writes to x0 still complete the handshake but never reach the file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_xfer && (w_gnt_addr != '0);
      if (w_xfer) begin
        r_waddr <= w_gnt_addr;
        r_wdata <= w_gnt_data;
      end
    end
  end

  assign rf_we    = r_we;
  assign rf_waddr = r_waddr;
  assign rf_wdata = r_wdata;

  logic [CNT_W-1:0]   r_cnt [NUM_REG];
  logic [NUM_REG-1:0] w_inc_vec;
  logic [NUM_REG-1:0] w_dec_vec;
  logic               w_dec_hit;
  logic               w_inc;

  // A commit landing on the same register this cycle frees a slot, so a
  // full counter can still accept the issue.
  assign w_dec_hit   = r_we && (r_waddr == issue_addr);
  assign issue_ready = !((r_cnt[issue_addr] == CNT_MAX) && !w_dec_hit);
  assign w_inc       = issue_valid && issue_ready && (issue_addr != '0);

  always_comb begin
    w_inc_vec = '0;
    w_dec_vec = '0;
    if (w_inc) w_inc_vec[issue_addr] = 1'b1;
    if (r_we)  w_dec_vec[r_waddr]    = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REG; r++) r_cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REG; r++) begin
        case ({w_inc_vec[r], w_dec_vec[r]})
          2'b10:   r_cnt[r] <= r_cnt[r] + CNT_W'(1);
          2'b01:   if (r_cnt[r] != '0) r_cnt[r] <= r_cnt[r] - CNT_W'(1);
          default: ;
        endcase
      end
    end
  end

  assign chk_busy1 = (chk_addr1 != '0) && (r_cnt[chk_addr1] != '0);
  assign chk_busy2 = (chk_addr2 != '0) && (r_cnt[chk_addr2] != '0);

  // Committing a register with nothing pending is an upstream protocol error.
  a_commit_pending: assert property (@(posedge clk) disable iff (reset)
    r_we |-> (r_cnt[r_waddr] != '0));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;
  localparam int N    = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int CW   = 2;
  localparam int NREG = 1 << AW;
  localparam int MAXC = (1 << CW) - 1;

  logic            clk;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [DW-1:0]   rf_wdata;
  logic            issue_valid;
  logic [AW-1:0]   issue_addr;
  logic            issue_ready;
  logic [AW-1:0]   chk_addr1;
  logic [AW-1:0]   chk_addr2;
  logic            chk_busy1;
  logic            chk_busy2;

  rf_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t exp_q[$];

  // Reference model: pending writes per register, issues not yet handed to a
  // requester, round-robin pointer, and the write expected on the port now.
  int m_cnt [NREG];
  int owed  [NREG];
  int m_ptr;
  bit m_we_now;
  int m_wa_now;
  int last_g;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREG; r++) begin
      m_cnt[r] = 0;
      owed[r]  = 0;
    end
    m_ptr    = 0;
    m_we_now = 1'b0;
    m_wa_now = 0;
    last_g   = -1;
    exp_q.delete();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]            = 1'b1;
    req_addr[i*AW +: AW]    = a;
    req_data[i*DW +: DW]    = d;
    if (a != '0) owed[a]    = owed[a] - 1;
  endtask

  // One clock cycle: inputs are already driven; check combinational outputs
  // at the falling edge, advance the model, return just after the next rise.
  task automatic step();
    int           g;
    logic [N-1:0] er;
    bit           ir;
    logic [AW-1:0] a;
    wr_t          e;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
`ifdef WB_FIXED_PRIO_EN
      idx = k;
`else
      idx = (m_ptr + k) % N;
`endif
      if (g < 0 && req_valid[idx]) g = idx;
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    ir = !(m_cnt[issue_addr] == MAXC && !(m_we_now && m_wa_now == int'(issue_addr)));
    chk("issue_ready", 64'(issue_ready), 64'(ir));
    chk("chk_busy1", 64'(chk_busy1), 64'(chk_addr1 != '0 && m_cnt[chk_addr1] != 0));
    chk("chk_busy2", 64'(chk_busy2), 64'(chk_addr2 != '0 && m_cnt[chk_addr2] != 0));
    if (issue_valid && ir && issue_addr != '0) begin
      m_cnt[issue_addr]++;
      owed[issue_addr]++;
    end
    if (m_we_now && m_cnt[m_wa_now] > 0) m_cnt[m_wa_now]--;
    last_g   = g;
    m_we_now = 1'b0;
    if (g >= 0) begin
      m_ptr = (g + 1) % N;
      a = req_addr[g*AW +: AW];
      if (a != '0) begin
        e.cyc = cyc + 1;
        e.a   = a;
        e.d   = req_data[g*DW +: DW];
        exp_q.push_back(e);
        m_we_now = 1'b1;
        m_wa_now = int'(a);
      end
    end
    @(posedge clk);
    #1;
    if (g >= 0) req_valid[g] = 1'b0;
  endtask

  task automatic do_issue(input logic [AW-1:0] a);
    issue_valid = 1'b1;
    issue_addr  = a;
    step();
    issue_valid = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    int s;
    s = $urandom_range(1, 7);
    if ($urandom_range(0, 5) == 0) return '0;
    for (int k = 0; k < 7; k++) begin
      int r;
      r = ((s - 1 + k) % 7) + 1;
      if (owed[r] > 0) return AW'(r);
    end
    return '0;
  endfunction

  // Write-port monitor: pops the expected write due this cycle.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
          e = exp_q.pop_front();
          chk("rf_we", 64'(rf_we), 64'(1));
          chk("rf_waddr", 64'(rf_waddr), 64'(e.a));
          chk("rf_wdata", 64'(rf_wdata), 64'(e.d));
          chk("write_cycle", 64'(cyc), 64'(e.cyc));
        end else begin
          chk("rf_we_idle", 64'(rf_we), 64'(0));
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    req_valid   = '0;
    req_addr    = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_addr  = '0;
    chk_addr1   = 5'd3;
    chk_addr2   = 5'd4;
    model_clear();
    #1;
    chk("rst_rf_we", 64'(rf_we), 64'(0));
    chk("rst_rf_waddr", 64'(rf_waddr), 64'(0));
    chk("rst_rf_wdata", 64'(rf_wdata), 64'(0));
    chk("rst_issue_ready", 64'(issue_ready), 64'(1));
    chk("rst_busy1", 64'(chk_busy1), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Round-robin with all three valid, fresh write after each grant.
    for (int r = 1; r <= 6; r++) do_issue(AW'(r));
    for (int i = 0; i < N; i++) set_req(i, AW'(i + 1), $urandom());
    for (int t = 0; t < 3; t++) begin
      step();
      if (last_g >= 0) set_req(last_g, AW'(last_g + 4), $urandom());
    end
    for (int t = 0; t < 6 && req_valid != '0; t++) step();
    step();
    step();

    // Single requester, then an x0 write that must not reach the file.
    do_issue(5'd7);
    set_req(1, 5'd7, 32'hDEADBEEF);
    step();
    step();
    step();
    set_req(0, 5'd0, 32'h1234);
    step();
    step();

    // Fill register 5 to saturation, try one more, then drain it.
    chk_addr1 = 5'd5;
    for (int t = 0; t < 3; t++) do_issue(5'd5);
    issue_addr = 5'd5;
    step();
    do_issue(5'd5);
    for (int t = 0; t < 3; t++) begin
      set_req(t, 5'd5, $urandom());
      step();
    end
    step();
    step();

    // Issue and commit to register 9 in the same cycle.
    chk_addr1 = 5'd9;
    do_issue(5'd9);
    set_req(2, 5'd9, $urandom());
    step();
    do_issue(5'd9);
    step();
    step();

    // Fixed-priority/round-robin contrast with 3'b101 held.
    for (int t = 0; t < 6; t++) begin
      if (!req_valid[0]) set_req(0, 5'd0, $urandom());
      if (!req_valid[2]) set_req(2, 5'd0, $urandom());
      step();
    end
    req_valid = '0;
    step();

    // Asynchronous reset while a write is on the port.
    do_issue(5'd10);
    do_issue(5'd11);
    do_issue(5'd10);
    chk_addr1 = 5'd10;
    chk_addr2 = 5'd11;
    set_req(0, 5'd10, $urandom());
    step();
    chk("pre_reset_rf_we", 64'(rf_we), 64'(m_we_now));
    #2;
    reset     = 1'b1;
    req_valid = '0;
    #1;
    chk("arst_rf_we", 64'(rf_we), 64'(0));
    chk("arst_rf_waddr", 64'(rf_waddr), 64'(0));
    chk("arst_rf_wdata", 64'(rf_wdata), 64'(0));
    chk("arst_busy1", 64'(chk_busy1), 64'(0));
    chk("arst_busy2", 64'(chk_busy2), 64'(0));
    chk("arst_issue_ready", 64'(issue_ready), 64'(1));
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step();
    for (int r = 12; r <= 14; r++) do_issue(AW'(r));
    for (int i = 0; i < N; i++) set_req(i, AW'(12 + i), $urandom());
    for (int t = 0; t < 4; t++) step();
    step();

    // Randomised traffic on a small register range to hit saturation.
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) set_req(i, pick_addr(), $urandom());
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_addr  = AW'($urandom_range(0, 7));
      chk_addr1   = AW'($urandom_range(0, 7));
      chk_addr2   = AW'($urandom_range(0, 7));
      step();
    end
    issue_valid = 1'b0;
    for (int t = 0; t < 20 && req_valid != '0; t++) step();
    step();
    step();
    step();
    chk("write_queue_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
